// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK flip-flops with per-bit Preset/Clear and shared JK/COUNT/SHIFT/TOGGLE mode.
// Optional change-tracking register enabled by defining JK_BANK_CHG_EN.
module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic [WIDTH-1:0] Preset,
    input  logic [WIDTH-1:0] Clear,
    input  logic             up_dn,
    input  logic             ser_in,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic             ser_out,
    output logic             tc,
    output logic [WIDTH-1:0] chg
);

    localparam logic [1:0] MODE_JK     = 2'b00;
    localparam logic [1:0] MODE_COUNT  = 2'b01;
    localparam logic [1:0] MODE_SHIFT  = 2'b10;
    localparam logic [1:0] MODE_TOGGLE = 2'b11;

    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] set_bits;
    logic [WIDTH-1:0] hold_bits;
    logic [WIDTH-1:0] free_bits;

    always_comb begin
        nxt = Q;
        case (mode)
            MODE_JK:     nxt = (J & ~Q) | (~K & Q);
            MODE_COUNT:  nxt = up_dn ? Q + 1'b1 : Q - 1'b1;
            MODE_SHIFT:  nxt = {Q[WIDTH-2:0], ser_in};
            MODE_TOGGLE: nxt = Q ^ J;
            default:     nxt = Q;
        endcase
    end

    // Overrides are applied bitwise on top of nxt, which was computed from the
    // un-overridden Q, so a forced bit never re-ripples a count carry.
    assign set_bits  = Preset & ~Clear;
    assign hold_bits = Preset & Clear;
    assign free_bits = ~(Preset | Clear);
    assign q_d       = set_bits | (hold_bits & Q) | (free_bits & (en ? nxt : Q));

    always_ff @(posedge clk) begin
        if (rst) Q <= RESET_VAL;
        else     Q <= q_d;
    end

    assign Q_bar   = ~Q;
    assign ser_out = Q[WIDTH-1];
    assign tc      = en && (mode == MODE_COUNT) &&
                     (up_dn ? (Q == {WIDTH{1'b1}}) : (Q == '0));

`ifdef JK_BANK_CHG_EN
    always_ff @(posedge clk) begin
        if (rst) chg <= '0;
        else     chg <= Q ^ q_d;
    end
`else
    assign chg = '0;
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH=4): directed scenarios plus a
// randomized run against an arithmetic reference model.
module tb_jk_reg_bank;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, en, up_dn, ser_in;
    logic [1:0]   mode;
    logic [W-1:0] J, K, Preset, Clear;
    logic [W-1:0] Q, Q_bar, chg;
    logic         ser_out, tc;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] mq;
    logic [W-1:0] mchg;

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(4'h0)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .J(J), .K(K),
        .Preset(Preset), .Clear(Clear), .up_dn(up_dn), .ser_in(ser_in),
        .Q(Q), .Q_bar(Q_bar), .ser_out(ser_out), .tc(tc), .chg(chg)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model_next(
        input logic [W-1:0] q, input logic r, input logic e, input logic [1:0] m,
        input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] p,
        input logic [W-1:0] c, input logic ud, input logic si);
        int qi, ni;
        logic [W-1:0] nx, res;
        if (r) return 4'h0;
        qi = int'(q);
        nx = q;
        case (m)
            2'd0: for (int i = 0; i < W; i++) begin
                if (j[i] && k[i])  nx[i] = !q[i];
                else if (j[i])     nx[i] = 1'b1;
                else if (k[i])     nx[i] = 1'b0;
                else               nx[i] = q[i];
            end
            2'd1: begin ni = ud ? (qi + 1) % 16 : (qi + 15) % 16; nx = ni[W-1:0]; end
            2'd2: begin ni = (qi * 2 + int'(si)) % 16; nx = ni[W-1:0]; end
            default: nx = q ^ j;
        endcase
        for (int i = 0; i < W; i++) begin
            if (p[i] && !c[i])      res[i] = 1'b1;
            else if (!p[i] && c[i]) res[i] = 1'b0;
            else if (p[i] && c[i])  res[i] = q[i];
            else                    res[i] = e ? nx[i] : q[i];
        end
        return res;
    endfunction

    function automatic logic model_tc(input logic [W-1:0] q, input logic e,
                                      input logic [1:0] m, input logic ud);
        return e && (m == 2'd1) && (ud ? (q == 4'hF) : (q == 4'h0));
    endfunction

    // Drive one edge's worth of inputs, wait past the edge, advance the model.
    task automatic apply(input logic r, input logic e, input logic [1:0] m,
                         input logic [W-1:0] j, input logic [W-1:0] k,
                         input logic [W-1:0] p, input logic [W-1:0] c,
                         input logic ud, input logic si);
        logic [W-1:0] nq;
        rst = r; en = e; mode = m; J = j; K = k; Preset = p; Clear = c;
        up_dn = ud; ser_in = si;
        nq = model_next(mq, r, e, m, j, k, p, c, ud, si);
        @(posedge clk);
        #1;
`ifdef JK_BANK_CHG_EN
        mchg = r ? 4'h0 : (mq ^ nq);
`else
        mchg = 4'h0;
`endif
        mq = nq;
    endtask

    task automatic force_q(input logic [W-1:0] v);
        apply(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, v, ~v, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        apply(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        force_q(4'hA);
        checks++;
        if (Q !== 4'hA) begin failures++; $display("FAIL preset_load Q=%h exp=%h", Q, 4'hA); end
        apply(1'b1, 1'b1, 2'd1, 4'hF, 4'h3, 4'hF, 4'h0, 1'b1, 1'b1);
        checks++;
        if (Q !== 4'h0) begin failures++; $display("FAIL reset_q Q=%h exp=0", Q); end
        checks++;
        if (Q_bar !== 4'hF) begin failures++; $display("FAIL reset_qbar Q_bar=%h exp=F", Q_bar); end
        checks++;
        if (chg !== 4'h0) begin failures++; $display("FAIL reset_chg chg=%h exp=0", chg); end
    endtask

    task automatic test_jk;
        force_q(4'b1100);
        apply(1'b0, 1'b1, 2'd0, 4'b1010, 4'b0110, 4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (Q !== 4'b1010) begin failures++; $display("FAIL jk_mode Q=%b exp=1010", Q); end
    endtask

    task automatic test_count;
        force_q(4'hE);
        rst = 1'b0; en = 1'b1; mode = 2'd1; up_dn = 1'b1; Preset = 4'h0; Clear = 4'h0;
        #1;
        checks++;
        if (tc !== 1'b0) begin failures++; $display("FAIL count_tc_at_E tc=%b exp=0", tc); end
        apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (Q !== 4'hF || tc !== 1'b1) begin failures++; $display("FAIL count_up_F Q=%h tc=%b exp=F/1", Q, tc); end
        apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
        checks++;
        if (Q !== 4'h0 || tc !== 1'b0) begin failures++; $display("FAIL count_up_wrap Q=%h tc=%b exp=0/0", Q, tc); end
        force_q(4'h1);
        apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (Q !== 4'h0 || tc !== 1'b1) begin failures++; $display("FAIL count_dn_0 Q=%h tc=%b exp=0/1", Q, tc); end
        apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (Q !== 4'hF) begin failures++; $display("FAIL count_dn_wrap Q=%h exp=F", Q); end
    endtask

    task automatic test_override;
        force_q(4'h3);
        apply(1'b0, 1'b1, 2'd1, 4'h0, 4'h0, 4'b1000, 4'b0001, 1'b1, 1'b0);
        checks++;
        if (Q !== 4'b1100) begin failures++; $display("FAIL override_count Q=%b exp=1100", Q); end
        force_q(4'h2);
        apply(1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 4'b0010, 4'b0010, 1'b1, 1'b0);
        checks++;
        if (Q !== 4'h2) begin failures++; $display("FAIL override_both_hold Q=%h exp=2", Q); end
    endtask

    task automatic test_shift;
        logic [W-1:0] exp_q [4];
        logic [3:0]   bits;
        exp_q[0] = 4'h1; exp_q[1] = 4'h2; exp_q[2] = 4'h5; exp_q[3] = 4'hB;
        bits = 4'b1101;
        force_q(4'h0);
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 1'b1, 2'd2, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, bits[i]);
            checks++;
            if (Q !== exp_q[i]) begin failures++; $display("FAIL shift_step%0d Q=%h exp=%h", i, Q, exp_q[i]); end
        end
        checks++;
        if (ser_out !== 1'b1) begin failures++; $display("FAIL shift_ser_out got=%b exp=1", ser_out); end
    endtask

    task automatic test_toggle_chg;
        logic [W-1:0] exp_chg;
`ifdef JK_BANK_CHG_EN
        exp_chg = 4'h5;
`else
        exp_chg = 4'h0;
`endif
        force_q(4'h0);
        apply(1'b0, 1'b1, 2'd3, 4'b0101, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
        checks++;
        if (Q !== 4'h5) begin failures++; $display("FAIL toggle_q Q=%h exp=5", Q); end
        checks++;
        if (chg !== exp_chg) begin failures++; $display("FAIL toggle_chg chg=%h exp=%h", chg, exp_chg); end
    endtask

    task automatic test_random;
        logic         r, e, ud, si;
        logic [1:0]   m;
        logic [W-1:0] j, k, p, c;
        int           bad = 0;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 19) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = 2'($urandom_range(0, 3));
            j  = 4'($urandom);
            k  = 4'($urandom);
            p  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            c  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            ud = 1'($urandom);
            si = 1'($urandom);
            rst = r; en = e; mode = m; up_dn = ud;
            #1;
            checks++;
            if (tc !== model_tc(mq, e, m, ud)) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_tc n=%0d tc=%b exp=%b", n, tc, model_tc(mq, e, m, ud));
            end
            apply(r, e, m, j, k, p, c, ud, si);
            checks++;
            if (Q !== mq || Q_bar !== ~mq || ser_out !== mq[W-1] || chg !== mchg) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_state n=%0d Q=%h Q_bar=%h ser_out=%b chg=%h exp Q=%h chg=%h",
                                       n, Q, Q_bar, ser_out, chg, mq, mchg);
            end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; J = '0; K = '0; Preset = '0; Clear = '0;
        up_dn = 1'b0; ser_in = 1'b0;
        mq = 4'h0; mchg = 4'h0;
        test_reset();
        test_jk();
        test_count();
        test_override();
        test_shift();
        test_toggle_chg();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
